// File: rtl/min_cost_scheduler.sv
// Serial minimum search over a bank of NUM_CAND candidate costs, one compare per cycle.
// Optional per-scan eligibility mask is enabled by defining MIN_SCHED_MASK_EN.
module min_cost_scheduler #(
  parameter int NUM_CAND = 12,
  parameter int DATA_W   = 32,
  parameter int IDX_W    = 4
) (
  input  logic              iClock,
  input  logic              iReset,
  input  logic              iEnable,
  input  logic              iWrite,
  input  logic [IDX_W-1:0]  iWAddr,
  input  logic [DATA_W-1:0] iWData,
  input  logic              iStart,
`ifdef MIN_SCHED_MASK_EN
  input  logic [NUM_CAND-1:0] iMask,
`endif
  output logic              oBusy,
  output logic              oDone,
  output logic [IDX_W-1:0]  oMinimum,
  output logic [DATA_W-1:0] oMinValue,
  output logic              oNoValid,
  output logic              oOverrun
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]          r_state;
  logic [DATA_W-1:0]   r_bank [NUM_CAND];
  logic [NUM_CAND-1:0] r_valid;
  logic [NUM_CAND-1:0] r_mask;
  logic [IDX_W-1:0]    r_ptr;
  logic [IDX_W-1:0]    r_minIdx;
  logic [DATA_W-1:0]   r_runMin;
  logic                r_found;
  logic                r_done;
  logic [IDX_W-1:0]    r_minimum;
  logic [DATA_W-1:0]   r_minValue;
  logic                r_noValid;
  logic                r_overrun;

  logic                w_idle;
  logic                w_wrAccept;
  logic                w_eligible;
  logic                w_lastPtr;
  logic [NUM_CAND-1:0] w_startMask;

`ifdef MIN_SCHED_MASK_EN
  assign w_startMask = iMask;
`else
  assign w_startMask = '1;
`endif

  assign w_idle     = (r_state == S_IDLE);
  assign w_wrAccept = iWrite && w_idle && (32'(iWAddr) < NUM_CAND);
  assign w_eligible = r_valid[r_ptr] && r_mask[r_ptr];
  assign w_lastPtr  = (32'(r_ptr) == NUM_CAND - 1);

  // Cost storage is never reset or cleared; only the valid bits gate eligibility.
  always_ff @(posedge iClock) begin
    if (iEnable && w_wrAccept) begin
      r_bank[iWAddr] <= iWData;
    end
  end

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      r_valid <= '0;
    end else if (iEnable) begin
      if (r_state == S_DONE) begin
        r_valid <= '0;
      end else if (w_wrAccept) begin
        r_valid[iWAddr] <= 1'b1;
      end
    end
  end

  // Strict less-than during the scan keeps the lowest index on ties.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_minIdx   <= '0;
      r_runMin   <= '1;
      r_found    <= 1'b0;
      r_mask     <= '0;
      r_done     <= 1'b0;
      r_minimum  <= '0;
      r_minValue <= '1;
      r_noValid  <= 1'b0;
      r_overrun  <= 1'b0;
    end else if (iEnable) begin
      r_done <= 1'b0;
      if (iWrite && !w_idle) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (iStart) begin
            r_state   <= S_SCAN;
            r_ptr     <= '0;
            r_minIdx  <= '0;
            r_runMin  <= '1;
            r_found   <= 1'b0;
            r_mask    <= w_startMask;
            r_overrun <= 1'b0;
          end
        end
        S_SCAN: begin
          if (w_eligible && (r_bank[r_ptr] < r_runMin)) begin
            r_runMin <= r_bank[r_ptr];
            r_minIdx <= r_ptr;
            r_found  <= 1'b1;
          end
          if (w_lastPtr) begin
            r_state <= S_DONE;
          end else begin
            r_ptr <= r_ptr + 1'b1;
          end
        end
        S_DONE: begin
          r_done     <= 1'b1;
          r_minimum  <= r_minIdx;
          r_minValue <= r_runMin;
          r_noValid  <= !r_found;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign oBusy     = (r_state == S_SCAN) || (r_state == S_DONE);
  assign oDone     = r_done;
  assign oMinimum  = r_minimum;
  assign oMinValue = r_minValue;
  assign oNoValid  = r_noValid;
  assign oOverrun  = r_overrun;

endmodule

// File: tb/tb_min_cost_scheduler.sv
// Randomized self-checking bench for min_cost_scheduler against a slot-array reference model.
// Mask scenarios are compiled in when MIN_SCHED_MASK_EN is defined.
module tb_min_cost_scheduler;
  localparam int NC = 12;
  localparam int DW = 32;
  localparam int IW = 4;
  localparam logic [DW-1:0] ONES = {DW{1'b1}};

  logic          iClock = 1'b0;
  logic          iReset, iEnable, iWrite, iStart;
  logic [IW-1:0] iWAddr;
  logic [DW-1:0] iWData;
`ifdef MIN_SCHED_MASK_EN
  logic [NC-1:0] iMask;
`endif
  logic          oBusy, oDone, oNoValid, oOverrun;
  logic [IW-1:0] oMinimum;
  logic [DW-1:0] oMinValue;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mBank [NC];
  bit            mValid[NC];
  bit            mMask [NC];

  int pattern[NC] = '{2000, 120, 30, 10000, 50, 12, 912, 56, 5128, 12002, 2002, 50};

  min_cost_scheduler #(.NUM_CAND(NC), .DATA_W(DW), .IDX_W(IW)) dut (
    .iClock(iClock), .iReset(iReset), .iEnable(iEnable), .iWrite(iWrite),
    .iWAddr(iWAddr), .iWData(iWData), .iStart(iStart),
`ifdef MIN_SCHED_MASK_EN
    .iMask(iMask),
`endif
    .oBusy(oBusy), .oDone(oDone), .oMinimum(oMinimum), .oMinValue(oMinValue),
    .oNoValid(oNoValid), .oOverrun(oOverrun)
  );

  always #5 iClock = ~iClock;

  // Expected result: smallest eligible cost first, then the lowest slot holding it.
  task automatic model_result(output logic [IW-1:0] eIdx, output logic [DW-1:0] eVal, output bit eNone);
    eNone = 1'b1;
    eVal  = ONES;
    eIdx  = '0;
    for (int i = 0; i < NC; i++)
      if (mValid[i] && mMask[i] && mBank[i] < eVal) begin eVal = mBank[i]; eNone = 1'b0; end
    if (!eNone) begin
      for (int i = NC - 1; i >= 0; i--)
        if (mValid[i] && mMask[i] && mBank[i] == eVal) eIdx = i[IW-1:0];
    end
  endtask

  task automatic applyStimulus(input int a, input logic [DW-1:0] d);
    iWrite = 1'b1; iWAddr = a[IW-1:0]; iWData = d;
    @(negedge iClock);
    iWrite = 1'b0;
    if (a < NC) begin mBank[a] = d; mValid[a] = 1'b1; end
  endtask

  task automatic load_pattern();
    for (int i = 0; i < NC; i++) applyStimulus(i, pattern[i]);
  endtask

  task automatic do_reset();
    iReset = 1'b1;
    @(negedge iClock);
    iReset = 1'b0;
    for (int i = 0; i < NC; i++) mValid[i] = 1'b0;
  endtask

  // Starts a scan and waits for oDone, optionally stalling or injecting a start/write mid-scan.
  task automatic run_scan(input int stallAt, input int stallLen, input int injectAt,
                          input bit injStart, input bit injWrite, output int lat, output int busyCnt);
    iStart = 1'b1;
    @(negedge iClock);
    iStart = 1'b0;
    lat = 0;
    busyCnt = 0;
    while (!oDone && lat < 60) begin
      if (oBusy) busyCnt++;
      iEnable = !(lat >= stallAt && lat < stallAt + stallLen);
      iStart  = injStart && (lat == injectAt);
      iWrite  = injWrite && (lat == injectAt);
      iWAddr  = '0;
      iWData  = 1;
      @(negedge iClock);
      lat++;
    end
    iStart = 1'b0; iWrite = 1'b0; iEnable = 1'b1;
    for (int i = 0; i < NC; i++) mValid[i] = 1'b0;
  endtask

  task automatic test_reset();
    iReset = 1'b1; iEnable = 1'b1; iWrite = 1'b0; iStart = 1'b0; iWAddr = '0; iWData = '0;
    #1;
    checks++;
    if (oBusy !== 1'b0 || oDone !== 1'b0 || oMinimum !== '0 || oMinValue !== ONES ||
        oNoValid !== 1'b0 || oOverrun !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_state: got busy=%b done=%b min=%0d val=%h nv=%b ov=%b required 0 0 0 ffffffff 0 0",
               oBusy, oDone, oMinimum, oMinValue, oNoValid, oOverrun);
    end
    @(negedge iClock);
    @(negedge iClock);
    iReset = 1'b0;
    @(negedge iClock);
  endtask

  task automatic test_basic();
    logic [IW-1:0] eIdx; logic [DW-1:0] eVal; bit eNone; int lat, busyCnt;
    load_pattern();
    model_result(eIdx, eVal, eNone);
    run_scan(100, 0, 100, 0, 0, lat, busyCnt);
    checks++;
    if (lat !== 13) begin errors++; $display("[TB] FAIL basic_latency: got %0d required 13", lat); end
    checks++;
    if (busyCnt !== 13) begin errors++; $display("[TB] FAIL basic_busy: got %0d required 13", busyCnt); end
    checks++;
    if (oMinimum !== eIdx || oMinValue !== eVal || oNoValid !== eNone || eIdx !== 5 || eVal !== 12) begin
      errors++;
      $display("[TB] FAIL basic_result: got %0d/%0d/%b required %0d/%0d/%b", oMinimum, oMinValue, oNoValid, eIdx, eVal, eNone);
    end
    @(negedge iClock);
    checks++;
    if (oDone !== 1'b0 || oMinimum !== eIdx || oMinValue !== eVal) begin
      errors++;
      $display("[TB] FAIL basic_pulse_hold: got done=%b %0d/%0d required 0 %0d/%0d", oDone, oMinimum, oMinValue, eIdx, eVal);
    end
  endtask

  task automatic test_tie();
    logic [IW-1:0] eIdx; logic [DW-1:0] eVal; bit eNone; int lat, busyCnt;
    for (int i = 0; i < NC; i++) applyStimulus(i, (i == 4 || i == 11) ? 50 : 1000);
    model_result(eIdx, eVal, eNone);
    run_scan(100, 0, 100, 0, 0, lat, busyCnt);
    checks++;
    if (oMinimum !== eIdx || oMinValue !== eVal || eIdx !== 4) begin
      errors++;
      $display("[TB] FAIL tie_result: got %0d/%0d required %0d/%0d", oMinimum, oMinValue, eIdx, eVal);
    end
  endtask

  task automatic test_no_valid();
    int lat, busyCnt;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      run_scan(100, 0, 100, 0, 0, lat, busyCnt);
      checks++;
      if (oMinimum !== '0 || oMinValue !== ONES || oNoValid !== 1'b1 || lat !== 13) begin
        errors++;
        $display("[TB] FAIL no_valid_%0d: got %0d/%h/%b lat=%0d required 0/ffffffff/1 lat=13",
                 k, oMinimum, oMinValue, oNoValid, lat);
      end
    end
  endtask

  task automatic test_start_while_busy();
    logic [IW-1:0] eIdx; logic [DW-1:0] eVal; bit eNone; int lat, busyCnt;
    load_pattern();
    model_result(eIdx, eVal, eNone);
    run_scan(100, 0, 3, 1, 0, lat, busyCnt);
    checks++;
    if (lat !== 13 || oMinimum !== eIdx || oMinValue !== eVal) begin
      errors++;
      $display("[TB] FAIL start_busy: got lat=%0d %0d/%0d required lat=13 %0d/%0d", lat, oMinimum, oMinValue, eIdx, eVal);
    end
    @(negedge iClock);
    checks++;
    if (oBusy !== 1'b0) begin errors++; $display("[TB] FAIL start_not_queued: got busy=%b required 0", oBusy); end
  endtask

  task automatic test_write_while_busy();
    logic [IW-1:0] eIdx; logic [DW-1:0] eVal; bit eNone; int lat, busyCnt;
    load_pattern();
    model_result(eIdx, eVal, eNone);
    run_scan(100, 0, 3, 0, 1, lat, busyCnt);
    checks++;
    if (oMinimum !== eIdx || oMinValue !== eVal || eIdx !== 5) begin
      errors++;
      $display("[TB] FAIL write_busy_result: got %0d/%0d required %0d/%0d", oMinimum, oMinValue, eIdx, eVal);
    end
    checks++;
    if (oOverrun !== 1'b1) begin errors++; $display("[TB] FAIL overrun_set: got %b required 1", oOverrun); end
    load_pattern();
    checks++;
    if (oOverrun !== 1'b1) begin errors++; $display("[TB] FAIL overrun_sticky: got %b required 1", oOverrun); end
    run_scan(100, 0, 100, 0, 0, lat, busyCnt);
    checks++;
    if (oOverrun !== 1'b0) begin errors++; $display("[TB] FAIL overrun_clear: got %b required 0", oOverrun); end
  endtask

  task automatic test_reset_mid_scan();
    int lat, busyCnt, sawDone;
    load_pattern();
    iStart = 1'b1;
    @(negedge iClock);
    iStart = 1'b0;
    repeat (6) @(negedge iClock);
    #1 iReset = 1'b1;
    #1;
    checks++;
    if (oBusy !== 1'b0 || oDone !== 1'b0 || oMinimum !== '0 || oMinValue !== ONES || oNoValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_scan: got busy=%b done=%b %0d/%h nv=%b required 0 0 0/ffffffff 0",
               oBusy, oDone, oMinimum, oMinValue, oNoValid);
    end
    @(negedge iClock);
    iReset = 1'b0;
    for (int i = 0; i < NC; i++) mValid[i] = 1'b0;
    sawDone = 0;
    repeat (20) begin @(negedge iClock); if (oDone) sawDone++; end
    checks++;
    if (sawDone !== 0) begin errors++; $display("[TB] FAIL reset_no_done: got %0d done cycles required 0", sawDone); end
    load_pattern();
    run_scan(100, 0, 100, 0, 0, lat, busyCnt);
    checks++;
    if (oMinimum !== 5 || oMinValue !== 12 || lat !== 13) begin
      errors++;
      $display("[TB] FAIL after_reset_result: got %0d/%0d lat=%0d required 5/12 lat=13", oMinimum, oMinValue, lat);
    end
  endtask

  task automatic test_enable_stall();
    logic [IW-1:0] eIdx; logic [DW-1:0] eVal; bit eNone; int lat, busyCnt;
    load_pattern();
    model_result(eIdx, eVal, eNone);
    run_scan(5, 4, 100, 0, 0, lat, busyCnt);
    checks++;
    if (lat !== 17 || oMinimum !== eIdx || oMinValue !== eVal) begin
      errors++;
      $display("[TB] FAIL enable_stall: got lat=%0d %0d/%0d required lat=17 %0d/%0d", lat, oMinimum, oMinValue, eIdx, eVal);
    end
  endtask

  task automatic test_write_with_start();
    logic [IW-1:0] eIdx; logic [DW-1:0] eVal; bit eNone; int lat, busyCnt;
    load_pattern();
    applyStimulus(13, 1);
    mBank[3] = 7; mValid[3] = 1'b1;
    model_result(eIdx, eVal, eNone);
    iWrite = 1'b1; iWAddr = 4'd3; iWData = 7;
    run_scan(100, 0, 100, 0, 0, lat, busyCnt);
    checks++;
    if (oMinimum !== eIdx || oMinValue !== eVal || eIdx !== 3) begin
      errors++;
      $display("[TB] FAIL write_with_start: got %0d/%0d required %0d/%0d", oMinimum, oMinValue, eIdx, eVal);
    end
  endtask

`ifdef MIN_SCHED_MASK_EN
  task automatic test_mask();
    logic [IW-1:0] eIdx; logic [DW-1:0] eVal; bit eNone; int lat, busyCnt;
    load_pattern();
    iMask = 12'hFDF;
    for (int i = 0; i < NC; i++) mMask[i] = (i != 5);
    model_result(eIdx, eVal, eNone);
    run_scan(100, 0, 100, 0, 0, lat, busyCnt);
    checks++;
    if (oMinimum !== eIdx || oMinValue !== eVal || eIdx !== 2 || eVal !== 30) begin
      errors++;
      $display("[TB] FAIL mask_bit5: got %0d/%0d required %0d/%0d", oMinimum, oMinValue, eIdx, eVal);
    end
    load_pattern();
    iMask = '0;
    run_scan(100, 0, 100, 0, 0, lat, busyCnt);
    checks++;
    if (oNoValid !== 1'b1 || oMinValue !== ONES || oMinimum !== '0) begin
      errors++;
      $display("[TB] FAIL mask_zero: got %0d/%h/%b required 0/ffffffff/1", oMinimum, oMinValue, oNoValid);
    end
    iMask = '1;
    for (int i = 0; i < NC; i++) mMask[i] = 1'b1;
  endtask
`endif

  task automatic test_random();
    logic [IW-1:0] eIdx; logic [DW-1:0] eVal; bit eNone; int lat, busyCnt, nWr, sAt, sLen;
    for (int it = 0; it < 25; it++) begin
      nWr = $urandom_range(0, 20);
      for (int w = 0; w < nWr; w++) applyStimulus($urandom_range(0, 15), $urandom_range(0, 300));
`ifdef MIN_SCHED_MASK_EN
      iMask = NC'($urandom);
      for (int i = 0; i < NC; i++) mMask[i] = iMask[i];
`endif
      model_result(eIdx, eVal, eNone);
      sAt  = $urandom_range(0, 12);
      sLen = $urandom_range(0, 3);
      run_scan(sAt, sLen, 100, 0, 0, lat, busyCnt);
      checks++;
      if (oMinimum !== eIdx || oMinValue !== eVal || oNoValid !== eNone || lat !== 13 + sLen) begin
        errors++;
        $display("[TB] FAIL random_%0d: got %0d/%0d/%b lat=%0d required %0d/%0d/%b lat=%0d",
                 it, oMinimum, oMinValue, oNoValid, lat, eIdx, eVal, eNone, 13 + sLen);
      end
    end
`ifdef MIN_SCHED_MASK_EN
    iMask = '1;
    for (int i = 0; i < NC; i++) mMask[i] = 1'b1;
`endif
  endtask

  initial begin
    for (int i = 0; i < NC; i++) begin mBank[i] = '0; mValid[i] = 1'b0; mMask[i] = 1'b1; end
`ifdef MIN_SCHED_MASK_EN
    iMask = '1;
`endif
    test_reset();
    test_basic();
    test_tie();
    test_no_valid();
    test_start_while_busy();
    test_write_while_busy();
    test_reset_mid_scan();
    test_enable_stall();
    test_write_with_start();
`ifdef MIN_SCHED_MASK_EN
    test_mask();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
